// File: rtl/uart_rx.sv
// UART receive stage: 2-flop line synchronizer, mid-bit sampling deframer with
// optional parity, and a one-entry holding register read by the bus side.
module uart_rx #(
    parameter int unsigned p_DIV_0 = 1042,
    parameter int unsigned p_DIV_1 = 521,
    parameter int unsigned p_DIV_2 = 174,
    parameter int unsigned p_DIV_3 = 87
) (
    input  logic       i_Pclk,
    input  logic       i_Reset,
    input  logic [1:0] i_Baud_Sel,
    input  logic       i_Parity_En,
    input  logic       i_Parity_Odd,
    input  logic       i_Rx_Serial,
    input  logic       i_Rx_Read,
    output logic [7:0] o_Rx_Data,
    output logic       o_Rx_Ready,
    output logic       o_Parity_Err,
    output logic       o_Frame_Err,
    output logic       o_Overrun,
    output logic       o_Busy
);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a low rx_s
    // S_START  | half-bit wait, then confirm the start bit
    // S_DATA   | eight data bits, LSB first
    // S_PARITY | parity bit (only when latched parity enable is set)
    // S_STOP   | stop bit sample, then load request
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, rx_s_q;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] div_q, div_d;
    logic [10:0] div_sel;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_en_q, par_en_d;
    logic        par_odd_q, par_odd_d;
    logic        par_err_q, par_err_d;
    logic        load, frame_err_ld;
    logic        half_end, bit_end;

    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        case (i_Baud_Sel)
            2'b00:   div_sel = 11'(p_DIV_0);
            2'b01:   div_sel = 11'(p_DIV_1);
            2'b10:   div_sel = 11'(p_DIV_2);
            default: div_sel = 11'(p_DIV_3);
        endcase
    end

    assign half_end = (cnt_q == ((div_q >> 1) - 11'd1));
    assign bit_end  = (cnt_q == (div_q - 11'd1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 11'd1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        div_d        = div_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        par_err_d    = par_err_q;
        load         = 1'b0;
        frame_err_ld = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) begin
                    state_d   = S_START;
                    div_d     = div_sel;
                    par_en_d  = i_Parity_En;
                    par_odd_d = i_Parity_Odd;
                    par_err_d = 1'b0;
                end
            end
            S_START: begin
                if (half_end) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    par_err_d = (^shift_q) ^ rx_s_q ^ par_odd_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Leave on the stop sample so a new start edge is caught early.
                if (bit_end) begin
                    cnt_d        = '0;
                    load         = 1'b1;
                    frame_err_ld = ~rx_s_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (i_Rx_Read && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (load) begin
            if (!ready_q || i_Rx_Read) begin
                data_d  = shift_q;
                perr_d  = par_err_q;
                ferr_d  = frame_err_ld;
                ready_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= i_Rx_Serial;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_Rx_Data    = data_q;
    assign o_Rx_Ready   = ready_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Overrun    = ovr_q;
    assign o_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the 115200 setting (87 clocks per bit, 10 MHz clock).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 87;

    logic       clk;
    logic       rst;
    logic [1:0] baud_sel;
    logic       par_en;
    logic       par_odd;
    logic       rx_line;
    logic       rd;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    int   cyc_cnt  = 0;
    int   fall_cyc = 0;
    int   rise_cyc = 0;
    logic rdy_prev = 1'b0;

    logic [7:0] snap_data;
    logic       snap_rdy, snap_perr, snap_ferr, snap_ovr, snap_busy;

    uart_rx dut (
        .i_Pclk       (clk),
        .i_Reset      (rst),
        .i_Baud_Sel   (baud_sel),
        .i_Parity_En  (par_en),
        .i_Parity_Odd (par_odd),
        .i_Rx_Serial  (rx_line),
        .i_Rx_Read    (rd),
        .o_Rx_Data    (rx_data),
        .o_Rx_Ready   (rx_ready),
        .o_Parity_Err (perr),
        .o_Frame_Err  (ferr),
        .o_Overrun    (ovr),
        .o_Busy       (busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        #1;
        if (rx_ready && !rdy_prev) rise_cyc = cyc_cnt;
        rdy_prev = rx_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // k counts edges after the falling start edge; rd_at/sel_at/rst_at = -1 disables.
    task automatic send_frame(input logic [7:0] data, input bit pen, input bit pbit,
                              input bit stop_bit, input int rd_at, input int sel_at,
                              input int rst_at);
        int   nbits;
        int   idx;
        logic lv;
        bit   aborted;
        nbits   = pen ? 11 : 10;
        aborted = 1'b0;
        @(posedge clk); #1;
        rx_line  = 1'b0;
        fall_cyc = cyc_cnt;
        for (int k = 1; k < nbits * BIT_CLKS + 40; k++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && k == rst_at + 1) begin
                snap_data = rx_data; snap_rdy = rx_ready; snap_perr = perr;
                snap_ferr = ferr;    snap_ovr = ovr;      snap_busy = busy;
            end
            idx = k / BIT_CLKS;
            if (idx == 0)                lv = 1'b0;
            else if (idx <= 8)           lv = data[idx-1];
            else if (idx == 9 && pen)    lv = pbit;
            else if (idx == nbits - 1)   lv = stop_bit;
            else                         lv = 1'b1;
            if (k == rst_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end else begin
                rst = 1'b0;
            end
            if (aborted) lv = 1'b1;
            rx_line = lv;
            rd      = (k == rd_at);
            if (k == sel_at) baud_sel = 2'b00;
        end
        rd = 1'b0;
    endtask

    task automatic read_pulse();
        @(posedge clk); #1;
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; baud_sel = 2'b11; par_en = 1'b0; par_odd = 1'b0;
        rx_line = 1'b1; rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_data", rx_data, 8'h00);
        check("rst_ready", rx_ready, 1'b0);
        check("rst_perr", perr, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_busy", busy, 1'b0);

        // basic receive, ready at fall + 2 (sync) + 827
        send_frame(8'h53, 0, 0, 1, -1, -1, -1);
        check("basic_ready", rx_ready, 1'b1);
        check("basic_data", rx_data, 8'h53);
        check("basic_perr", perr, 1'b0);
        check("basic_ferr", ferr, 1'b0);
        check("basic_ovr", ovr, 1'b0);
        check("basic_latency", rise_cyc - fall_cyc, 829);
        check("basic_busy", busy, 1'b0);
        read_pulse();
        check("basic_rd_ready", rx_ready, 1'b0);
        check("basic_rd_data", rx_data, 8'h53);

        // parity: 0xA5 has four ones
        par_en = 1'b1; par_odd = 1'b0;
        send_frame(8'hA5, 1, 0, 1, -1, -1, -1);
        check("par_even_ok_ready", rx_ready, 1'b1);
        check("par_even_ok_perr", perr, 1'b0);
        check("par_even_ok_data", rx_data, 8'hA5);
        read_pulse();
        send_frame(8'hA5, 1, 1, 1, -1, -1, -1);
        check("par_even_bad_perr", perr, 1'b1);
        check("par_even_bad_data", rx_data, 8'hA5);
        read_pulse();
        check("par_rd_keeps_perr", perr, 1'b1);
        par_odd = 1'b1;
        send_frame(8'hA5, 1, 1, 1, -1, -1, -1);
        check("par_odd_ok_perr", perr, 1'b0);
        check("par_odd_ok_ready", rx_ready, 1'b1);
        read_pulse();
        par_en = 1'b0; par_odd = 1'b0;

        // framing error
        send_frame(8'h3C, 0, 0, 0, -1, -1, -1);
        check("frame_ferr", ferr, 1'b1);
        check("frame_data", rx_data, 8'h3C);
        check("frame_ready", rx_ready, 1'b1);
        check("frame_ovr", ovr, 1'b0);
        read_pulse();
        repeat (1000) @(posedge clk);
        read_pulse();
        check("frame_after_ready", rx_ready, 1'b0);
        check("frame_after_busy", busy, 1'b0);

        // overrun
        send_frame(8'h11, 0, 0, 1, -1, -1, -1);
        check("ovr_first_ferr", ferr, 1'b0);
        send_frame(8'h22, 0, 0, 1, -1, -1, -1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_flag", ovr, 1'b1);
        check("ovr_ready", rx_ready, 1'b1);
        read_pulse();
        check("ovr_rd_ready", rx_ready, 1'b0);
        check("ovr_rd_flag", ovr, 1'b0);
        check("ovr_rd_data", rx_data, 8'h11);
        send_frame(8'h33, 0, 0, 1, -1, -1, -1);
        send_frame(8'h55, 0, 0, 1, -1, -1, -1);
        check("ovr2_flag", ovr, 1'b1);
        check("ovr2_data", rx_data, 8'h33);
        send_frame(8'h44, 0, 0, 1, 828, -1, -1);
        check("ovr_simul_data", rx_data, 8'h44);
        check("ovr_simul_ready", rx_ready, 1'b1);
        check("ovr_simul_flag", ovr, 1'b0);
        read_pulse();
        check("ovr_final_ready", rx_ready, 1'b0);

        // 20-clock glitch is rejected
        @(posedge clk); #1 rx_line = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("glitch_ready", rx_ready, 1'b0);
        check("glitch_busy", busy, 1'b0);

        // baud select changes mid-frame, latched rate still used
        send_frame(8'h96, 0, 0, 1, -1, 300, -1);
        check("cfg_data", rx_data, 8'h96);
        check("cfg_ready", rx_ready, 1'b1);
        check("cfg_ferr", ferr, 1'b0);
        check("cfg_ovr", ovr, 1'b0);
        baud_sel = 2'b11;

        // reset during bit 4 with a full holding register
        send_frame(8'hAB, 0, 0, 1, -1, -1, 470);
        check("midrst_data", snap_data, 8'h00);
        check("midrst_ready", snap_rdy, 1'b0);
        check("midrst_perr", snap_perr, 1'b0);
        check("midrst_ferr", snap_ferr, 1'b0);
        check("midrst_ovr", snap_ovr, 1'b0);
        check("midrst_busy", snap_busy, 1'b0);
        check("midrst_idle_ready", rx_ready, 1'b0);
        send_frame(8'hC3, 0, 0, 1, -1, -1, -1);
        check("postrst_data", rx_data, 8'hC3);
        check("postrst_ready", rx_ready, 1'b1);
        check("postrst_perr", perr, 1'b0);
        check("postrst_ferr", ferr, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
